// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: FSM encoding and duty resolution.
package pwm_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_RISE = 2'd1;
  localparam logic [1:0] MEAS_HIGH = 2'd2;
  localparam logic [1:0] MEAS_LOW  = 2'd3;

  typedef enum logic [1:0] {
    StIdle     = IDLE,
    StWaitRise = WAIT_RISE,
    StMeasHigh = MEAS_HIGH,
    StMeasLow  = MEAS_LOW
  } state_e;

  localparam int unsigned PWM_RES  = 8;
  localparam int unsigned DUTY_MAX = 255;

endpackage

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider: quot = floor(high * DUTY_MAX / period), one quotient bit per cycle.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [Width-1:0]   high_i,
  input  logic [Width-1:0]   period_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [PWM_RES-1:0] quot_o
);

  localparam int unsigned NumW  = Width + PWM_RES;
  localparam int unsigned IterW = $clog2(PWM_RES);

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [IterW-1:0]   iter_q, iter_d;
  logic [Width-1:0]   rem_q, rem_d;
  logic [Width-1:0]   den_q, den_d;
  logic [PWM_RES-1:0] low_q, low_d;
  logic [PWM_RES-1:0] quot_q, quot_d;
  logic [PWM_RES-1:0] result_q, result_d;
  logic [NumW-1:0]    num;
  logic [Width:0]     trial;
  logic               take;

  always_comb begin
    num      = NumW'(high_i) * NumW'(DUTY_MAX);
    trial    = {rem_q, low_q[PWM_RES-1]};
    take     = trial >= {1'b0, den_q};
    busy_d   = busy_q;
    done_d   = 1'b0;
    iter_d   = iter_q;
    rem_d    = rem_q;
    den_d    = den_q;
    low_d    = low_q;
    quot_d   = quot_q;
    result_d = result_q;
    if (busy_q) begin
      rem_d  = take ? Width'(trial - {1'b0, den_q}) : trial[Width-1:0];
      low_d  = low_q << 1;
      quot_d = {quot_q[PWM_RES-2:0], take};
      iter_d = iter_q + IterW'(1);
      if (iter_q == IterW'(PWM_RES - 1)) begin
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = quot_d;
      end
    end else if (start_i) begin
      // high <= period keeps the upper numerator bits below the divisor, so 8 bits suffice.
      rem_d  = num[NumW-1:PWM_RES];
      low_d  = num[PWM_RES-1:0];
      den_d  = period_i;
      quot_d = '0;
      iter_d = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      iter_q   <= '0;
      rem_q    <= '0;
      den_q    <= '0;
      low_q    <= '0;
      quot_q   <= '0;
      result_q <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      iter_q   <= iter_d;
      rem_q    <= rem_d;
      den_q    <= den_d;
      low_q    <= low_d;
      quot_q   <= quot_d;
      result_q <= result_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = result_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input, with stuck-input timeout.
// Optional duty output and divider enabled by defining PWM_CAPTURE_DUTY_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 16'hFFFF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 pwm_input,
  output logic [CNT_WIDTH-1:0] high_count,
  output logic [CNT_WIDTH-1:0] period_count,
  output logic                 meas_valid,
  output logic                 stuck_high,
  output logic                 stuck_low
`ifdef PWM_CAPTURE_DUTY_EN
  ,
  output logic [PWM_RES-1:0]   duty,
  output logic                 duty_valid
`endif
);

  localparam logic [CNT_WIDTH-1:0] TimeoutCnt = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] One        = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d_q;
  logic                   sync_in, rise, fall;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CNT_WIDTH-1:0]   high_cap_q, high_cap_d;
  logic [CNT_WIDTH-1:0]   high_count_q, high_count_d;
  logic [CNT_WIDTH-1:0]   period_count_q, period_count_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   stuck_high_q, stuck_high_d;
  logic                   stuck_low_q, stuck_low_d;

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign rise    = sync_in & ~sync_d_q;
  assign fall    = ~sync_in & sync_d_q;
  // Saturate so an edge landing exactly on TIMEOUT cannot push the counter past it.
  assign cnt_inc = (cnt_q == TimeoutCnt) ? cnt_q : cnt_q + One;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    high_cap_d     = high_cap_q;
    high_count_d   = high_count_q;
    period_count_d = period_count_q;
    meas_valid_d   = 1'b0;
    stuck_high_d   = stuck_high_q;
    stuck_low_d    = stuck_low_q;
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          state_d = StWaitRise;
        end
        StWaitRise: begin
          if (rise) begin
            cnt_d   = One;
            state_d = StMeasHigh;
          end
        end
        StMeasHigh: begin
          cnt_d = cnt_inc;
          if (fall) begin
            high_cap_d = cnt_q;
            state_d    = StMeasLow;
          end else if (cnt_q == TimeoutCnt) begin
            high_count_d   = TimeoutCnt;
            period_count_d = TimeoutCnt;
            stuck_high_d   = 1'b1;
            meas_valid_d   = 1'b1;
            cnt_d          = '0;
            state_d        = StWaitRise;
          end
        end
        StMeasLow: begin
          cnt_d = cnt_inc;
          if (rise) begin
            high_count_d   = high_cap_q;
            period_count_d = cnt_q;
            meas_valid_d   = 1'b1;
            stuck_high_d   = 1'b0;
            stuck_low_d    = 1'b0;
            cnt_d          = One;
            state_d        = StMeasHigh;
          end else if (cnt_q == TimeoutCnt) begin
            high_count_d   = '0;
            period_count_d = TimeoutCnt;
            stuck_low_d    = 1'b1;
            meas_valid_d   = 1'b1;
            cnt_d          = '0;
            state_d        = StWaitRise;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q         <= '0;
      sync_d_q       <= 1'b0;
      state_q        <= StIdle;
      cnt_q          <= '0;
      high_cap_q     <= '0;
      high_count_q   <= '0;
      period_count_q <= '0;
      meas_valid_q   <= 1'b0;
      stuck_high_q   <= 1'b0;
      stuck_low_q    <= 1'b0;
    end else begin
      sync_q         <= {sync_q[SYNC_STAGES-2:0], pwm_input};
      sync_d_q       <= sync_in;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      high_cap_q     <= high_cap_d;
      high_count_q   <= high_count_d;
      period_count_q <= period_count_d;
      meas_valid_q   <= meas_valid_d;
      stuck_high_q   <= stuck_high_d;
      stuck_low_q    <= stuck_low_d;
    end
  end

  assign high_count   = high_count_q;
  assign period_count = period_count_q;
  assign meas_valid   = meas_valid_q;
  assign stuck_high   = stuck_high_q;
  assign stuck_low    = stuck_low_q;

`ifdef PWM_CAPTURE_DUTY_EN
  logic div_busy;
  logic div_start;

  // Strobes arriving mid-division are dropped; duty keeps the last completed result.
  assign div_start = meas_valid_q && (period_count_q != '0) && !div_busy;

  pwm_duty_div #(
    .Width(CNT_WIDTH)
  ) u_duty_div (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .start_i (div_start),
    .high_i  (high_count_q),
    .period_i(period_count_q),
    .busy_o  (div_busy),
    .done_o  (duty_valid),
    .quot_o  (duty)
  );
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture; duty checks active when PWM_CAPTURE_DUTY_EN is set.
module tb_pwm_capture;

  localparam int unsigned CW = 16;
  localparam int unsigned SS = 2;
  localparam int unsigned TO = 1000;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          pwm_input;
  logic [CW-1:0] high_count;
  logic [CW-1:0] period_count;
  logic          meas_valid;
  logic          stuck_high;
  logic          stuck_low;
`ifdef PWM_CAPTURE_DUTY_EN
  logic [7:0]    duty;
  logic          duty_valid;
`endif

  pwm_capture #(
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(SS),
    .TIMEOUT    (TO)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .pwm_input   (pwm_input),
    .high_count  (high_count),
    .period_count(period_count),
    .meas_valid  (meas_valid),
    .stuck_high  (stuck_high),
    .stuck_low   (stuck_low)
`ifdef PWM_CAPTURE_DUTY_EN
    ,
    .duty        (duty),
    .duty_valid  (duty_valid)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    int   hi;
    int   per;
    logic sh;
    logic sl;
  } rec_t;

  rec_t mlog[$];
  int   dcyc[$];
  int   dval[$];

  always @(posedge clock) begin
    #1;
    if (meas_valid === 1'b1)
      mlog.push_back('{cyc, int'(high_count), int'(period_count), stuck_high, stuck_low});
  end

`ifdef PWM_CAPTURE_DUTY_EN
  always @(posedge clock) begin
    #1;
    if (duty_valid === 1'b1) begin
      dcyc.push_back(cyc);
      dval.push_back(int'(duty));
    end
  end
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_period(input int h, input int p);
    pwm_input = 1'b1;
    cycles(h);
    pwm_input = 1'b0;
    cycles(p - h);
  endtask

  task automatic restart();
    enable    = 1'b0;
    pwm_input = 1'b0;
    cycles(5);
    enable = 1'b1;
    cycles(5);
    mlog.delete();
    dcyc.delete();
    dval.delete();
  endtask

  task automatic check_rec(input string tag, input int idx, input int hi, input int per,
                           input int sh, input int sl);
    if (idx >= mlog.size()) begin
      check({tag, "_present"}, mlog.size(), idx + 1);
    end else begin
      check({tag, "_high"}, mlog[idx].hi, hi);
      check({tag, "_period"}, mlog[idx].per, per);
      check({tag, "_stuck_high"}, int'(mlog[idx].sh), sh);
      check({tag, "_stuck_low"}, int'(mlog[idx].sl), sl);
    end
  endtask

  task automatic check_duty(input string tag, input int exp);
`ifdef PWM_CAPTURE_DUTY_EN
    if (dcyc.size() == 0 || mlog.size() == 0) begin
      check({tag, "_duty_present"}, dcyc.size(), 1);
    end else begin
      check({tag, "_duty_latency"}, dcyc[dcyc.size()-1] - mlog[mlog.size()-1].cyc, 9);
      check({tag, "_duty"}, dval[dval.size()-1], exp);
    end
`else
    if (tag.len() > 0 && exp < 0) $display("unused duty tag %s", tag);
`endif
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    pwm_input = 1'b0;
    cycles(3);
    check("rst_high_count", int'(high_count), 0);
    check("rst_period_count", int'(period_count), 0);
    check("rst_meas_valid", int'(meas_valid), 0);
    check("rst_stuck_high", int'(stuck_high), 0);
    check("rst_stuck_low", int'(stuck_low), 0);
    reset_n = 1'b1;
    cycles(2);

    // 127/510: first rise only arms the measurement.
    restart();
    drive_period(127, 510);
    drive_period(127, 510);
    pwm_input = 1'b1;
    cycles(20);
    check("t1_strobes", mlog.size(), 2);
    check_rec("t1_m0", 0, 127, 510, 0, 0);
    check_rec("t1_m1", 1, 127, 510, 0, 0);
    if (mlog.size() == 2) check("t1_spacing", mlog[1].cyc - mlog[0].cyc, 510);
    check_duty("t1", 63);

    // 63/510 over three full periods.
    restart();
    for (int i = 0; i < 3; i++) drive_period(63, 510);
    pwm_input = 1'b1;
    cycles(20);
    check("t2_strobes", mlog.size(), 3);
    for (int i = 0; i < 3; i++) check_rec($sformatf("t2_m%0d", i), i, 63, 510, 0, 0);
    for (int i = 1; i < 3 && i < mlog.size(); i++)
      check($sformatf("t2_spacing%0d", i), mlog[i].cyc - mlog[i-1].cyc, 510);
    check_duty("t2", 31);

    // Stuck high, then recovery on a normal 191/510 waveform.
    restart();
    pwm_input = 1'b1;
    cycles(1100);
    check("t3_strobes", mlog.size(), 1);
    check_rec("t3_stuck", 0, 1000, 1000, 1, 0);
    check_duty("t3_stuck", 255);
    pwm_input = 1'b0;
    cycles(20);
    check("t3_stuck_hold", int'(stuck_high), 1);
    drive_period(191, 510);
    pwm_input = 1'b1;
    cycles(20);
    check("t3_strobes2", mlog.size(), 2);
    check_rec("t3_recover", 1, 191, 510, 0, 0);
    check_duty("t3_recover", 95);

    // Stuck low after one fall.
    restart();
    pwm_input = 1'b1;
    cycles(50);
    pwm_input = 1'b0;
    cycles(1100);
    check("t4_strobes", mlog.size(), 1);
    check_rec("t4_stuck", 0, 0, 1000, 0, 1);
    check_duty("t4", 0);

    // Enable dropped in MEAS_LOW: no strobes, outputs hold, first period after re-enable discarded.
    restart();
    drive_period(100, 400);
    pwm_input = 1'b1;
    cycles(100);
    pwm_input = 1'b0;
    cycles(50);
    enable    = 1'b0;
    pwm_input = 1'b1;
    cycles(100);
    pwm_input = 1'b0;
    cycles(100);
    check("t5_strobes_disabled", mlog.size(), 1);
    check_rec("t5_m0", 0, 100, 400, 0, 0);
    check("t5_hold_high", int'(high_count), 100);
    check("t5_hold_period", int'(period_count), 400);
    check("t5_valid_low", int'(meas_valid), 0);
    enable = 1'b1;
    drive_period(150, 450);
    pwm_input = 1'b1;
    cycles(20);
    check("t5_strobes", mlog.size(), 2);
    check_rec("t5_m1", 1, 150, 450, 0, 0);
    check_duty("t5", 85);

    // Reset pulse while in MEAS_HIGH.
    cycles(30);
    reset_n = 1'b0;
    #1;
    check("t6_rst_high", int'(high_count), 0);
    check("t6_rst_period", int'(period_count), 0);
    check("t6_rst_valid", int'(meas_valid), 0);
    @(negedge clock);
    reset_n   = 1'b1;
    pwm_input = 1'b0;
    mlog.delete();
    dcyc.delete();
    dval.delete();
    cycles(10);
    drive_period(200, 500);
    pwm_input = 1'b1;
    cycles(20);
    check("t6_strobes", mlog.size(), 1);
    check_rec("t6_m0", 0, 200, 500, 0, 0);
    check_duty("t6", 102);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
